// File: rtl/aes_tag_finalize.sv
// GCM tag finalization: T = ((S ^ L) * H) ^ E(K,J0) using a digit-serial GF(2^128) multiply.
// Define TAG_COMPARE_EN to add the decrypt-path tag comparison (i_expected_tag / o_auth_fail).
module aes_tag_finalize #(
  parameter int unsigned DIGIT_BITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] i_cipher_text,
  input  logic [2:0]   i_phase,
  input  logic         i_tag_ready,
  input  logic [127:0] i_tag,
  input  logic [127:0] i_h,
  input  logic [127:0] i_encrypted_j0,
  input  logic [127:0] i_instance_size,
  input  logic         i_tag_accept,
  output logic [127:0] o_cipher_text,
  output logic [2:0]   o_phase,
  output logic [127:0] o_tag,
  output logic         o_tag_valid,
  output logic         o_busy,
  output logic         o_overflow
`ifdef TAG_COMPARE_EN
  ,
  input  logic [127:0] i_expected_tag,
  output logic         o_auth_fail
`endif
);

  localparam int unsigned N  = 128 / DIGIT_BITS;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [127:0] R = {8'he1, 120'd0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t         state;
  logic [127:0]   x;
  logic [127:0]   v;
  logic [127:0]   z;
  logic [127:0]   j;
  logic [CW-1:0]  cnt;
  logic [127:0]   z_n;
  logic [127:0]   v_n;
`ifdef TAG_COMPARE_EN
  logic [127:0]   exp_tag;
`endif

  // Vector bit 127 is the x^0 coefficient, so X is consumed from the top and V shifts toward bit 0.
  always_comb begin
    z_n = z;
    v_n = v;
    for (int k = 0; k < int'(DIGIT_BITS); k++) begin
      if (x[127-k]) z_n = z_n ^ v_n;
      v_n = v_n[0] ? ((v_n >> 1) ^ R) : (v_n >> 1);
    end
  end

  // Passthrough pipeline register, independent of the tag FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_cipher_text <= '0;
      o_phase       <= '0;
    end else begin
      o_cipher_text <= i_cipher_text;
      o_phase       <= i_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      v           <= '0;
      z           <= '0;
      j           <= '0;
      cnt         <= '0;
      o_tag       <= '0;
      o_tag_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_overflow  <= 1'b0;
`ifdef TAG_COMPARE_EN
      exp_tag     <= '0;
      o_auth_fail <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_tag_ready) begin
            x      <= i_tag ^ i_instance_size;
            v      <= i_h;
            z      <= '0;
            j      <= i_encrypted_j0;
            cnt    <= '0;
`ifdef TAG_COMPARE_EN
            exp_tag <= i_expected_tag;
`endif
            state  <= MUL;
            o_busy <= 1'b1;
          end
        end
        MUL: begin
          z   <= z_n;
          v   <= v_n;
          x   <= x << DIGIT_BITS;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            o_tag       <= z_n ^ j;
            o_tag_valid <= 1'b1;
`ifdef TAG_COMPARE_EN
            o_auth_fail <= (z_n ^ j) != exp_tag;
`endif
            state       <= OUT;
          end
          if (i_tag_ready) o_overflow <= 1'b1;
        end
        OUT: begin
          // A tag arriving alongside the accept is still dropped, not captured.
          if (i_tag_accept) begin
            o_tag_valid <= 1'b0;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end
          if (i_tag_ready) o_overflow <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_tag_finalize.sv
// Directed self-checking bench for aes_tag_finalize using NIST GCM test cases 1 and 2.
module tb_aes_tag_finalize;

  localparam logic [127:0] H    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] J0E  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] S2   = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] L2   = 128'h80;
  localparam logic [127:0] T1   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] T2   = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] i_cipher_text;
  logic [2:0]   i_phase;
  logic         i_tag_ready;
  logic [127:0] i_tag;
  logic [127:0] i_h;
  logic [127:0] i_encrypted_j0;
  logic [127:0] i_instance_size;
  logic         i_tag_accept;
  logic [127:0] o_cipher_text;
  logic [2:0]   o_phase;
  logic [127:0] o_tag;
  logic         o_tag_valid;
  logic         o_busy;
  logic         o_overflow;
  logic [127:0] i_expected_tag;
`ifdef TAG_COMPARE_EN
  logic         o_auth_fail;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_tag_finalize #(.DIGIT_BITS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_cipher_text   (i_cipher_text),
    .i_phase         (i_phase),
    .i_tag_ready     (i_tag_ready),
    .i_tag           (i_tag),
    .i_h             (i_h),
    .i_encrypted_j0  (i_encrypted_j0),
    .i_instance_size (i_instance_size),
    .i_tag_accept    (i_tag_accept),
    .o_cipher_text   (o_cipher_text),
    .o_phase         (o_phase),
    .o_tag           (o_tag),
    .o_tag_valid     (o_tag_valid),
    .o_busy          (o_busy),
    .o_overflow      (o_overflow)
`ifdef TAG_COMPARE_EN
    ,
    .i_expected_tag  (i_expected_tag),
    .o_auth_fail     (o_auth_fail)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one tag request for a single edge; returns 1ns after the capturing edge.
  task automatic capture(input logic [127:0] s, input logic [127:0] sz, input logic [127:0] ex);
    @(negedge clk);
    i_tag           = s;
    i_instance_size = sz;
    i_h             = H;
    i_encrypted_j0  = J0E;
    i_expected_tag  = ex;
    i_tag_ready     = 1'b1;
    @(posedge clk);
    #1 i_tag_ready = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!o_tag_valid && edges < 40) begin
      @(posedge clk);
      #1 edges++;
    end
  endtask

  task automatic accept_tag();
    @(negedge clk);
    i_tag_accept = 1'b1;
    @(posedge clk);
    #1 i_tag_accept = 1'b0;
  endtask

  initial begin
    int   edges;
    logic stable;

    rst             = 1'b1;
    i_cipher_text   = '0;
    i_phase         = '0;
    i_tag_ready     = 1'b0;
    i_tag           = '0;
    i_h             = '0;
    i_encrypted_j0  = '0;
    i_instance_size = '0;
    i_tag_accept    = 1'b0;
    i_expected_tag  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tag", o_tag, '0);
    check("rst_valid", 128'(o_tag_valid), '0);
    check("rst_busy", 128'(o_busy), '0);
    check("rst_overflow", 128'(o_overflow), '0);
    @(negedge clk) rst = 1'b0;

    // Passthrough is one register stage.
    i_cipher_text = 128'h0123456789abcdeffedcba9876543210;
    i_phase       = 3'd5;
    @(posedge clk);
    #1;
    check("pass_ct", o_cipher_text, 128'h0123456789abcdeffedcba9876543210);
    check("pass_phase", 128'(o_phase), 128'd5);

    // Case 1: zero accumulator and lengths.
    capture('0, '0, T1);
    check("c1_busy", 128'(o_busy), 128'd1);
    wait_valid(edges);
    check("c1_latency", 128'(edges), 128'd16);
    check("c1_tag", o_tag, T1);
    accept_tag();
    check("c1_valid_drop", 128'(o_tag_valid), '0);
    check("c1_busy_drop", 128'(o_busy), '0);
    check("c1_tag_hold", o_tag, T1);

    // Case 2, with correct expected tag on the compare path.
    capture(S2, L2, T2);
    wait_valid(edges);
    check("c2_latency", 128'(edges), 128'd16);
    check("c2_tag", o_tag, T2);
`ifdef TAG_COMPARE_EN
    check("c2_auth_ok", 128'(o_auth_fail), '0);
`endif
    // Backpressure: tag and valid must hold while accept is low.
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1 if (o_tag !== T2 || o_tag_valid !== 1'b1 || o_busy !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", 128'(stable), 128'd1);
    accept_tag();
    check("bp_valid_drop", 128'(o_tag_valid), '0);
    check("bp_busy_drop", 128'(o_busy), '0);

    // Case 2 again with a corrupted expected tag; also verifies capture after backpressure.
    capture(S2, L2, T2 ^ {1'b1, 127'd0});
    wait_valid(edges);
    check("c2b_tag", o_tag, T2);
`ifdef TAG_COMPARE_EN
    check("c2b_auth_fail", 128'(o_auth_fail), 128'd1);
`endif
    check("c2b_no_overflow", 128'(o_overflow), '0);
    accept_tag();

    // Overflow: second request three cycles into MUL must not disturb the first.
    capture(S2, L2, T2);
    repeat (3) @(posedge clk);
    i_tag       = '0;
    i_instance_size = '0;
    i_tag_ready = 1'b1;
    @(posedge clk);
    #1 i_tag_ready = 1'b0;
    check("ovf_flag", 128'(o_overflow), 128'd1);
    check("ovf_busy", 128'(o_busy), 128'd1);
    wait_valid(edges);
    check("ovf_tag", o_tag, T2);
    accept_tag();
    check("ovf_sticky", 128'(o_overflow), 128'd1);

    // Reset at MUL cnt=7 clears every output on the next edge.
    capture(S2, L2, T2);
    repeat (7) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_tag", o_tag, '0);
    check("mrst_valid", 128'(o_tag_valid), '0);
    check("mrst_busy", 128'(o_busy), '0);
    check("mrst_overflow", 128'(o_overflow), '0);
    check("mrst_ct", o_cipher_text, '0);
    check("mrst_phase", 128'(o_phase), '0);
    @(negedge clk) rst = 1'b0;

    capture('0, '0, T1);
    wait_valid(edges);
    check("post_rst_latency", 128'(edges), 128'd16);
    check("post_rst_tag", o_tag, T1);

    // Accept coinciding with a new request in OUT: request dropped, overflow set.
    @(negedge clk);
    i_tag           = S2;
    i_instance_size = L2;
    i_tag_accept    = 1'b1;
    i_tag_ready     = 1'b1;
    @(posedge clk);
    #1;
    i_tag_accept = 1'b0;
    i_tag_ready  = 1'b0;
    check("acc_ovf_valid", 128'(o_tag_valid), '0);
    check("acc_ovf_flag", 128'(o_overflow), 128'd1);
    @(posedge clk);
    #1;
    check("acc_ovf_not_captured", 128'(o_busy), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
